// File: rtl/kb_lock_tracker.sv
// Tracks Caps/Num/Scroll lock state from PS/2 scan-code bytes and raises a
// one-cycle LED-update request whenever the lock state needs to be pushed to the keyboard.
module kb_lock_tracker #(
  parameter logic [7:0] CAPS_CODE   = 8'h58,
  parameter logic [7:0] NUM_CODE    = 8'h77,
  parameter logic [7:0] SCROLL_CODE = 8'h7E,
  parameter logic [2:0] INIT_LEDS   = 3'b000,
  parameter bit         INIT_SYNC   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       led_busy,
  output logic       led_req,
  output logic [2:0] led_val,
  output logic [2:0] lock_state
);

  localparam int unsigned LockW   = 3;
  localparam int unsigned SkipW   = 3;
  localparam logic [SkipW-1:0] SkipLen = SkipW'(7);

  localparam logic [7:0] ByteBrk = 8'hF0;
  localparam logic [7:0] ByteExt = 8'hE0;
  localparam logic [7:0] BytePau = 8'hE1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BRK     = 3'd1,
    EXT     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [SkipW-1:0]   cnt_q, cnt_d;
  logic [LockW-1:0]   held_q, held_d;
  logic [LockW-1:0]   lock_q, lock_d;
  logic [LockW-1:0]   val_q, val_d;
  logic               pending_q, pending_d;
  logic               guard_q, guard_d;
  logic               req_q, req_d;

  logic [LockW-1:0]   hit;
  logic [LockW-1:0]   toggle;
  logic               is_resp;
  logic               issue;

  // Bit order matches the LED word: {caps, num, scroll}
  assign hit = {rx_data == CAPS_CODE, rx_data == NUM_CODE, rx_data == SCROLL_CODE};

  // Keyboard response / error bytes never count as key events
  assign is_resp = (rx_data == 8'hFA) || (rx_data == 8'hFE) || (rx_data == 8'hAA) ||
                   (rx_data == 8'hEE) || (rx_data == 8'h00) || (rx_data == 8'hFF);

  // Guard masks the cycle(s) before the writer's busy flag becomes visible
  assign issue = pending_q & ~led_busy & ~guard_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_q    <= '0;
      lock_q    <= INIT_LEDS;
      val_q     <= INIT_LEDS;
      pending_q <= INIT_SYNC;
      guard_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= held_d;
      lock_q    <= lock_d;
      val_q     <= val_d;
      pending_q <= pending_d;
      guard_q   <= guard_d;
      req_q     <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    toggle  = '0;

    if (rx_done_tick) begin
      unique case (state_q)
        IDLE: begin
          if (rx_data == ByteBrk) begin
            state_d = BRK;
          end else if (rx_data == ByteExt) begin
            state_d = EXT;
          end else if (rx_data == BytePau) begin
            state_d = SKIP;
            cnt_d   = SkipLen;
          end else if (!is_resp) begin
            // Held bits suppress typematic repeats of an already-pressed lock key
            toggle = hit & ~held_q;
            held_d = held_q | hit;
          end
        end
        BRK: begin
          held_d  = held_q & ~hit;
          state_d = IDLE;
        end
        EXT:     state_d = (rx_data == ByteBrk) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        SKIP: begin
          cnt_d = cnt_q - SkipW'(1);
          if (cnt_q <= SkipW'(1)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    lock_d    = lock_q ^ toggle;
    pending_d = (pending_q & ~issue) | (|toggle);
    guard_d   = issue;
    req_d     = issue;
    val_d     = issue ? lock_q : val_q;
  end

  assign led_req    = req_q;
  assign led_val    = val_q;
  assign lock_state = lock_q;

endmodule

// File: tb/tb_kb_lock_tracker.sv
// Bench for kb_lock_tracker: directed vector table, hand-written reset sequence,
// and randomized bytes/busy checked against a byte-level reference model.
module tb_kb_lock_tracker;

  localparam logic [2:0] INIT = 3'b010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       led_busy = 1'b0;
  logic       led_req;
  logic [2:0] led_val;
  logic [2:0] lock_state;

  kb_lock_tracker #(
    .CAPS_CODE  (8'h58),
    .NUM_CODE   (8'h77),
    .SCROLL_CODE(8'h7E),
    .INIT_LEDS  (INIT),
    .INIT_SYNC  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_done_tick(rx_done_tick),
    .rx_data     (rx_data),
    .led_busy    (led_busy),
    .led_req     (led_req),
    .led_val     (led_val),
    .lock_state  (lock_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: lock/held bits indexed 2=caps, 1=num, 0=scroll
  bit [2:0] m_lock, m_held, m_val;
  bit       m_pend, m_guard, m_req;
  int       m_skip;
  bit       m_brk, m_ext;

  typedef struct {
    logic       tick;
    logic [7:0] data;
    logic       busy;
    logic [2:0] lock;
    logic       req;
    logic [2:0] val;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect3(input string nm, input logic [2:0] lk, input logic rq, input logic [2:0] vl);
    chk({nm, "_lock"}, int'(lock_state), int'(lk));
    chk({nm, "_req"}, int'(led_req), int'(rq));
    chk({nm, "_val"}, int'(led_val), int'(vl));
  endtask

  function automatic int code_idx(input logic [7:0] d);
    if (d == 8'h58) return 2;
    if (d == 8'h77) return 1;
    if (d == 8'h7E) return 0;
    return -1;
  endfunction

  task automatic model_reset();
    m_lock = INIT; m_val = INIT; m_held = '0;
    m_pend = 1'b1; m_guard = 1'b0; m_req = 1'b0;
    m_skip = 0; m_brk = 1'b0; m_ext = 1'b0;
  endtask

  // One clock edge of the reference model; request decision uses pre-edge state
  task automatic model_edge(input logic tick, input logic [7:0] d, input logic busy);
    bit issue, tog;
    int idx;
    issue = m_pend && !busy && !m_guard;
    if (issue) m_val = m_lock;
    tog = 1'b0;
    if (tick) begin
      idx = code_idx(d);
      if (m_skip > 0) m_skip--;
      else if (m_brk) begin
        m_brk = 1'b0;
        if (idx >= 0) m_held[idx] = 1'b0;
      end else if (m_ext) begin
        m_ext = 1'b0;
        if (d == 8'hF0) m_skip = 1;
      end else if (d == 8'hF0) m_brk = 1'b1;
      else if (d == 8'hE0) m_ext = 1'b1;
      else if (d == 8'hE1) m_skip = 7;
      else if (idx >= 0 && !m_held[idx]) begin
        m_held[idx] = 1'b1;
        m_lock[idx] = ~m_lock[idx];
        tog = 1'b1;
      end
    end
    m_req   = issue;
    m_guard = issue;
    m_pend  = (m_pend && !issue) || tog;
  endtask

  task automatic step(input logic tick, input logic [7:0] d, input logic busy);
    rx_done_tick = tick;
    rx_data      = d;
    led_busy     = busy;
    @(posedge clk);
    model_edge(tick, d, busy);
    #1;
  endtask

  // Asserts reset between edges, checks the async reset values, releases after an edge
  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    rx_done_tick = 1'b0;
    led_busy = 1'b0;
    model_reset();
    #2;
    expect3(nm, INIT, 1'b0, INIT);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add(input logic t, input logic [7:0] d, input logic b,
                     input logic [2:0] lk, input logic rq, input logic [2:0] vl);
    vec_t v;
    v.tick = t; v.data = d; v.busy = b; v.lock = lk; v.req = rq; v.val = vl;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] quiet [15];
    logic [7:0] pool [12];
    int busy_cnt;
    logic b;

    quiet = '{8'hE0, 8'h77, 8'hE0, 8'hF0, 8'h77, 8'hE1, 8'h14, 8'h77,
              8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hFA, 8'hAA};
    pool  = '{8'h58, 8'h77, 8'h7E, 8'hF0, 8'hF0, 8'hE0, 8'hE1,
              8'hFA, 8'hAA, 8'h14, 8'h00, 8'h12};

    // Power-up sync request carrying INIT
    add(0, 8'h00, 0, 3'b010, 1, 3'b010);
    add(0, 8'h00, 1, 3'b010, 0, 3'b010);
    add(0, 8'h00, 0, 3'b010, 0, 3'b010);
    // Caps make, typematic repeats, break, then a fresh make
    add(1, 8'h58, 0, 3'b110, 0, 3'b010);
    add(1, 8'h58, 0, 3'b110, 1, 3'b110);
    add(1, 8'h58, 1, 3'b110, 0, 3'b110);
    add(1, 8'hF0, 1, 3'b110, 0, 3'b110);
    add(1, 8'h58, 0, 3'b110, 0, 3'b110);
    add(0, 8'h00, 0, 3'b110, 0, 3'b110);
    add(1, 8'h58, 0, 3'b010, 0, 3'b110);
    add(0, 8'h00, 0, 3'b010, 1, 3'b010);
    add(0, 8'h00, 1, 3'b010, 0, 3'b010);
    add(1, 8'hF0, 0, 3'b010, 0, 3'b010);
    add(1, 8'h58, 0, 3'b010, 0, 3'b010);
    // Prefixed sequences, Pause and response bytes change nothing
    foreach (quiet[i]) add(1, quiet[i], 0, 3'b010, 0, 3'b010);
    add(1, 8'h7E, 0, 3'b011, 0, 3'b010);
    add(0, 8'h00, 0, 3'b011, 1, 3'b011);
    add(0, 8'h00, 1, 3'b011, 0, 3'b011);
    add(1, 8'hF0, 0, 3'b011, 0, 3'b011);
    add(1, 8'h7E, 0, 3'b011, 0, 3'b011);
    // Toggles while busy coalesce into one request with the latest state
    add(1, 8'h77, 1, 3'b001, 0, 3'b011);
    add(1, 8'hF0, 1, 3'b001, 0, 3'b011);
    add(1, 8'h77, 1, 3'b001, 0, 3'b011);
    add(1, 8'h7E, 1, 3'b000, 0, 3'b011);
    add(0, 8'h00, 0, 3'b000, 1, 3'b000);
    add(0, 8'h00, 1, 3'b000, 0, 3'b000);
    add(1, 8'hF0, 0, 3'b000, 0, 3'b000);
    add(1, 8'h7E, 0, 3'b000, 0, 3'b000);
    // Toggle on the issue cycle: old value first, guard cycle, then the new value
    add(1, 8'h58, 0, 3'b100, 0, 3'b000);
    add(1, 8'h77, 0, 3'b110, 1, 3'b100);
    add(0, 8'h00, 0, 3'b110, 0, 3'b100);
    add(0, 8'h00, 1, 3'b110, 0, 3'b100);
    add(0, 8'h00, 0, 3'b110, 1, 3'b110);
    add(0, 8'h00, 1, 3'b110, 0, 3'b110);
    add(1, 8'hF0, 0, 3'b110, 0, 3'b110);
    add(1, 8'h58, 0, 3'b110, 0, 3'b110);
    add(1, 8'hF0, 0, 3'b110, 0, 3'b110);
    add(1, 8'h77, 0, 3'b110, 0, 3'b110);

    #1;
    do_reset("reset");
    foreach (vecs[i]) begin
      step(vecs[i].tick, vecs[i].data, vecs[i].busy);
      expect3($sformatf("vec%0d", i), vecs[i].lock, vecs[i].req, vecs[i].val);
    end

    // Reset while a break prefix is outstanding: next caps byte is a make again
    step(1, 8'h7E, 0); expect3("mr_scroll", 3'b111, 0, 3'b110);
    step(0, 8'h00, 0); expect3("mr_req1",   3'b111, 1, 3'b111);
    step(0, 8'h00, 1);
    step(1, 8'h58, 0); expect3("mr_caps",   3'b011, 0, 3'b111);
    step(0, 8'h00, 0); expect3("mr_req2",   3'b011, 1, 3'b011);
    step(0, 8'h00, 1);
    step(1, 8'hF0, 0); expect3("mr_brk",    3'b011, 0, 3'b011);
    do_reset("mr_reset");
    step(0, 8'h00, 0); expect3("mr_sync",   3'b010, 1, 3'b010);
    step(0, 8'h00, 1);
    step(1, 8'h58, 0); expect3("mr_make",   3'b110, 0, 3'b010);
    step(0, 8'h00, 0); expect3("mr_req3",   3'b110, 1, 3'b110);

    // Randomized bytes and busy handshakes against the reference model
    do_reset("rnd_reset");
    busy_cnt = 0;
    for (int i = 0; i < 4000; i++) begin
      b = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
      step(1'($urandom_range(0, 1)), pool[$urandom_range(0, 11)], b);
      chk("rnd_lock", int'(lock_state), int'(m_lock));
      chk("rnd_req",  int'(led_req),    int'(m_req));
      chk("rnd_val",  int'(led_val),    int'(m_val));
      if (m_req) busy_cnt = $urandom_range(1, 6);
      else if (busy_cnt == 0 && $urandom_range(0, 40) == 0) busy_cnt = $urandom_range(1, 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
